// File: rtl/execute_stage.sv
// execute_stage: third pipeline stage. Qualifies each decoded instruction, computes the
// ALU result / memory address / link value, resolves branch and jump redirects back to
// fetch, registers the result bundle for the memory stage and counts retired instructions.
// All state moves on the falling clock edge so it lines up with decode's output latch.
module execute_stage #(
  parameter int unsigned RETIRE_CNT_WIDTH = 32,
  parameter int unsigned PC_WIDTH         = 32,
  parameter int unsigned REG_WIDTH        = 32,
  parameter int unsigned OPCODE_WIDTH     = 8
) (
  input  logic                        I_CLOCK,
  input  logic                        I_RESET_N,
  input  logic                        I_LOCK,
  input  logic [PC_WIDTH-1:0]         I_PC,
  input  logic [OPCODE_WIDTH-1:0]     I_Opcode,
  input  logic [REG_WIDTH-1:0]        I_Src1Value,
  input  logic [REG_WIDTH-1:0]        I_Src2Value,
  input  logic [3:0]                  I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]        I_DestValue,
  input  logic [REG_WIDTH-1:0]        I_Imm,
  input  logic                        I_FetchStall,
  input  logic                        I_DepStall,
  output logic                        O_LOCK,
  output logic [OPCODE_WIDTH-1:0]     O_Opcode,
  output logic [REG_WIDTH-1:0]        O_ALUOut,
  output logic [3:0]                  O_DestRegIdx,
  output logic [REG_WIDTH-1:0]        O_DestValue,
  output logic                        O_FetchStall,
  output logic                        O_DepStall,
  output logic [PC_WIDTH-1:0]         O_BranchPC,
  output logic                        O_BranchAddrSelect,
  output logic [RETIRE_CNT_WIDTH-1:0] O_RetireCount
);

  // Opcode encoding shared with decode.
  localparam logic [OPCODE_WIDTH-1:0] OpAddD  = OPCODE_WIDTH'(8'h00);
  localparam logic [OPCODE_WIDTH-1:0] OpAddiD = OPCODE_WIDTH'(8'h01);
  localparam logic [OPCODE_WIDTH-1:0] OpAndD  = OPCODE_WIDTH'(8'h02);
  localparam logic [OPCODE_WIDTH-1:0] OpAndiD = OPCODE_WIDTH'(8'h03);
  localparam logic [OPCODE_WIDTH-1:0] OpMov   = OPCODE_WIDTH'(8'h04);
  localparam logic [OPCODE_WIDTH-1:0] OpMoviD = OPCODE_WIDTH'(8'h05);
  localparam logic [OPCODE_WIDTH-1:0] OpLdw   = OPCODE_WIDTH'(8'h06);
  localparam logic [OPCODE_WIDTH-1:0] OpStw   = OPCODE_WIDTH'(8'h07);
  localparam logic [OPCODE_WIDTH-1:0] OpBrn   = OPCODE_WIDTH'(8'h08);
  localparam logic [OPCODE_WIDTH-1:0] OpBrz   = OPCODE_WIDTH'(8'h09);
  localparam logic [OPCODE_WIDTH-1:0] OpBrp   = OPCODE_WIDTH'(8'h0A);
  localparam logic [OPCODE_WIDTH-1:0] OpBrnz  = OPCODE_WIDTH'(8'h0B);
  localparam logic [OPCODE_WIDTH-1:0] OpBrnp  = OPCODE_WIDTH'(8'h0C);
  localparam logic [OPCODE_WIDTH-1:0] OpBrzp  = OPCODE_WIDTH'(8'h0D);
  localparam logic [OPCODE_WIDTH-1:0] OpBrnzp = OPCODE_WIDTH'(8'h0E);
  localparam logic [OPCODE_WIDTH-1:0] OpJmp   = OPCODE_WIDTH'(8'h0F);
  localparam logic [OPCODE_WIDTH-1:0] OpJsr   = OPCODE_WIDTH'(8'h10);
  localparam logic [OPCODE_WIDTH-1:0] OpJsrr  = OPCODE_WIDTH'(8'h11);

  typedef enum logic [0:0] {StIdle, StRedirect} state_e;

  state_e                      state_q, state_d;
  logic                        lock_q, lock_d;
  logic [OPCODE_WIDTH-1:0]     opcode_q, opcode_d;
  logic [REG_WIDTH-1:0]        alu_out_q, alu_out_d;
  logic [3:0]                  dest_reg_idx_q, dest_reg_idx_d;
  logic [REG_WIDTH-1:0]        dest_value_q, dest_value_d;
  logic                        fetch_stall_q, fetch_stall_d;
  logic                        dep_stall_q, dep_stall_d;
  logic [PC_WIDTH-1:0]         branch_pc_q, branch_pc_d;
  logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

  logic                        valid;
  logic                        alu_wr;
  logic [REG_WIDTH-1:0]        alu_res;
  logic                        redirect;

  // The PC is carried by decode but nothing here depends on it.
  logic unused_pc;
  assign unused_pc = ^I_PC;

  assign valid = I_LOCK & ~I_FetchStall & ~I_DepStall;

  // Opcode decode: ALU result and whether the instruction redirects fetch.
  always_comb begin
    alu_wr   = 1'b0;
    alu_res  = '0;
    redirect = 1'b0;
    case (I_Opcode)
      OpAddD:  begin alu_wr = 1'b1; alu_res = I_Src1Value + I_Src2Value; end
      OpAddiD: begin alu_wr = 1'b1; alu_res = I_Src1Value + I_Imm;       end
      OpAndD:  begin alu_wr = 1'b1; alu_res = I_Src1Value & I_Src2Value; end
      OpAndiD: begin alu_wr = 1'b1; alu_res = I_Src1Value & I_Imm;       end
      OpMov:   begin alu_wr = 1'b1; alu_res = I_Src1Value;               end
      OpMoviD: begin alu_wr = 1'b1; alu_res = I_Imm;                     end
      OpLdw,
      OpStw:   begin alu_wr = 1'b1; alu_res = I_Src1Value + I_Imm;       end
      // Src1 carries the link PC for subroutine calls.
      OpJsr,
      OpJsrr:  begin alu_wr = 1'b1; alu_res = I_Src1Value; redirect = 1'b1; end
      OpBrn, OpBrz, OpBrp, OpBrnz, OpBrnp, OpBrzp, OpBrnzp,
      OpJmp:   redirect = 1'b1;
      // Unknown opcodes retire but leave the result untouched.
      default: ;
    endcase
  end

  // Next-state: bubbles only refresh lock/stall markers; valid instructions update the bundle.
  always_comb begin
    lock_d         = I_LOCK;
    fetch_stall_d  = I_FetchStall;
    dep_stall_d    = I_DepStall;
    opcode_d       = opcode_q;
    alu_out_d      = alu_out_q;
    dest_reg_idx_d = dest_reg_idx_q;
    dest_value_d   = dest_value_q;
    branch_pc_d    = branch_pc_q;
    retire_cnt_d   = retire_cnt_q;
    // Redirect lasts exactly one edge unless another valid redirect follows.
    state_d        = StIdle;
    if (valid) begin
      opcode_d       = I_Opcode;
      dest_reg_idx_d = I_DestRegIdx;
      dest_value_d   = I_DestValue;
      retire_cnt_d   = retire_cnt_q + 1'b1;
      if (alu_wr) begin
        alu_out_d = alu_res;
      end
      if (redirect) begin
        branch_pc_d = PC_WIDTH'(I_DestValue);
        state_d     = StRedirect;
      end
    end
  end

  // Stage registers on the falling edge with synchronous active-low reset.
  always_ff @(negedge I_CLOCK) begin
    if (!I_RESET_N) begin
      state_q        <= StIdle;
      lock_q         <= 1'b0;
      opcode_q       <= '0;
      alu_out_q      <= '0;
      dest_reg_idx_q <= '0;
      dest_value_q   <= '0;
      fetch_stall_q  <= 1'b0;
      dep_stall_q    <= 1'b0;
      branch_pc_q    <= '0;
      retire_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      lock_q         <= lock_d;
      opcode_q       <= opcode_d;
      alu_out_q      <= alu_out_d;
      dest_reg_idx_q <= dest_reg_idx_d;
      dest_value_q   <= dest_value_d;
      fetch_stall_q  <= fetch_stall_d;
      dep_stall_q    <= dep_stall_d;
      branch_pc_q    <= branch_pc_d;
      retire_cnt_q   <= retire_cnt_d;
    end
  end

  assign O_LOCK             = lock_q;
  assign O_Opcode           = opcode_q;
  assign O_ALUOut           = alu_out_q;
  assign O_DestRegIdx       = dest_reg_idx_q;
  assign O_DestValue        = dest_value_q;
  assign O_FetchStall       = fetch_stall_q;
  assign O_DepStall         = dep_stall_q;
  assign O_BranchPC         = branch_pc_q;
  assign O_BranchAddrSelect = (state_q == StRedirect);
  assign O_RetireCount      = retire_cnt_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, ALU ops, bubbles, redirects, JSR, counter wrap.
module tb_execute_stage;

  localparam int unsigned CW = 4;

  localparam logic [7:0] OpAddD  = 8'h00;
  localparam logic [7:0] OpAddiD = 8'h01;
  localparam logic [7:0] OpAndD  = 8'h02;
  localparam logic [7:0] OpAndiD = 8'h03;
  localparam logic [7:0] OpMov   = 8'h04;
  localparam logic [7:0] OpMoviD = 8'h05;
  localparam logic [7:0] OpLdw   = 8'h06;
  localparam logic [7:0] OpStw   = 8'h07;
  localparam logic [7:0] OpBrz   = 8'h09;
  localparam logic [7:0] OpJmp   = 8'h0F;
  localparam logic [7:0] OpJsr   = 8'h10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lock;
  logic [31:0]   pc;
  logic [7:0]    opcode;
  logic [31:0]   src1, src2, dest_value, imm;
  logic [3:0]    dest_idx;
  logic          fetch_stall, dep_stall;

  logic          o_lock;
  logic [7:0]    o_opcode;
  logic [31:0]   o_alu;
  logic [3:0]    o_dest_idx;
  logic [31:0]   o_dest_value;
  logic          o_fetch_stall, o_dep_stall;
  logic [31:0]   o_branch_pc;
  logic          o_branch_sel;
  logic [CW-1:0] o_retire;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [CW-1:0] exp_cnt;

  always #5 clk = ~clk;

  execute_stage #(
    .RETIRE_CNT_WIDTH(CW),
    .PC_WIDTH        (32),
    .REG_WIDTH       (32),
    .OPCODE_WIDTH    (8)
  ) dut (
    .I_CLOCK           (clk),
    .I_RESET_N         (rst_n),
    .I_LOCK            (lock),
    .I_PC              (pc),
    .I_Opcode          (opcode),
    .I_Src1Value       (src1),
    .I_Src2Value       (src2),
    .I_DestRegIdx      (dest_idx),
    .I_DestValue       (dest_value),
    .I_Imm             (imm),
    .I_FetchStall      (fetch_stall),
    .I_DepStall        (dep_stall),
    .O_LOCK            (o_lock),
    .O_Opcode          (o_opcode),
    .O_ALUOut          (o_alu),
    .O_DestRegIdx      (o_dest_idx),
    .O_DestValue       (o_dest_value),
    .O_FetchStall      (o_fetch_stall),
    .O_DepStall        (o_dep_stall),
    .O_BranchPC        (o_branch_pc),
    .O_BranchAddrSelect(o_branch_sel),
    .O_RetireCount     (o_retire)
  );

  // One active (falling) edge, then settle at the following rising edge to sample.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] im, input logic [3:0] di, input logic [31:0] dv);
    opcode = op; src1 = s1; src2 = s2; imm = im; dest_idx = di; dest_value = dv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lock = 1'b1; fetch_stall = 1'b0; dep_stall = 1'b0; pc = 32'h10;
    drive(OpAddD, 32'd5, 32'd7, 32'd0, 4'd3, 32'd0);
    repeat (3) tick();
    n_cmp++; if (o_lock !== 1'b0) begin n_fail++; $display("FAIL rst_lock got %b want 0", o_lock); end
    n_cmp++; if (o_alu !== 32'd0) begin n_fail++; $display("FAIL rst_alu got %h want 0", o_alu); end
    n_cmp++; if ({o_opcode, o_dest_idx, o_dest_value, o_branch_pc} !== '0) begin
      n_fail++; $display("FAIL rst_data got %h/%h/%h/%h want 0", o_opcode, o_dest_idx,
                         o_dest_value, o_branch_pc);
    end
    n_cmp++; if ({o_fetch_stall, o_dep_stall, o_branch_sel} !== 3'b000) begin
      n_fail++; $display("FAIL rst_flags got %b%b%b want 000", o_fetch_stall, o_dep_stall,
                         o_branch_sel);
    end
    n_cmp++; if (o_retire !== 4'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", o_retire); end
    rst_n = 1'b1;
    tick();
    exp_cnt = 4'd1;
    n_cmp++; if (o_alu !== 32'd12) begin n_fail++; $display("FAIL first_add got %0d want 12", o_alu); end
    n_cmp++; if (o_retire !== exp_cnt) begin n_fail++; $display("FAIL first_cnt got %0d want %0d", o_retire, exp_cnt); end
    n_cmp++; if (o_lock !== 1'b1) begin n_fail++; $display("FAIL first_lock got %b want 1", o_lock); end
  endtask

  task automatic test_alu();
    logic [7:0]  ops [8];
    logic [31:0] s1s [8];
    logic [31:0] s2s [8];
    logic [31:0] ims [8];
    logic [31:0] exp [8];
    ops = '{OpAddD, OpAddiD, OpAndD, OpAndiD, OpMov, OpMoviD, OpLdw, OpStw};
    s1s = '{32'h8000_0001, 32'hFFFF_FFFF, 32'h0FF0, 32'hF0F0, 32'h1234_5678, 32'h5, 32'h200, 32'h100};
    s2s = '{32'h8000_0002, 32'h0, 32'h3C3C, 32'h0, 32'h9, 32'h9, 32'h0, 32'h0};
    ims = '{32'h0, 32'h1, 32'h0, 32'h00FF, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h8};
    exp = '{32'h3, 32'h0, 32'h0C30, 32'h00F0, 32'h1234_5678, 32'hFFFF_FFFE, 32'h1FC, 32'h108};
    for (int i = 0; i < 8; i++) begin
      drive(ops[i], s1s[i], s2s[i], ims[i], 4'(i + 1), 32'hAB);
      tick();
      exp_cnt++;
      n_cmp++; if (o_alu !== exp[i]) begin n_fail++; $display("FAIL alu_op%0d got %h want %h", i, o_alu, exp[i]); end
      n_cmp++; if (o_opcode !== ops[i]) begin n_fail++; $display("FAIL alu_opc%0d got %h want %h", i, o_opcode, ops[i]); end
    end
    n_cmp++; if (o_dest_value !== 32'hAB) begin n_fail++; $display("FAIL stw_data got %h want ab", o_dest_value); end
    n_cmp++; if (o_dest_idx !== 4'd8) begin n_fail++; $display("FAIL stw_idx got %0d want 8", o_dest_idx); end
    n_cmp++; if (o_branch_sel !== 1'b0) begin n_fail++; $display("FAIL alu_nostrobe got %b want 0", o_branch_sel); end
    n_cmp++; if (o_retire !== exp_cnt) begin n_fail++; $display("FAIL alu_cnt got %0d want %0d", o_retire, exp_cnt); end
  endtask

  task automatic test_bubble();
    drive(OpAddD, 32'd5, 32'd7, 32'd0, 4'd2, 32'd0);
    tick();
    exp_cnt++;
    n_cmp++; if (o_alu !== 32'd12) begin n_fail++; $display("FAIL bub_pre got %0d want 12", o_alu); end
    dep_stall = 1'b1; src1 = 32'd99;
    tick();
    n_cmp++; if (o_alu !== 32'd12) begin n_fail++; $display("FAIL bub_alu got %0d want 12", o_alu); end
    n_cmp++; if (o_dep_stall !== 1'b1) begin n_fail++; $display("FAIL bub_dep got %b want 1", o_dep_stall); end
    n_cmp++; if (o_retire !== exp_cnt) begin n_fail++; $display("FAIL bub_cnt got %0d want %0d", o_retire, exp_cnt); end
    fetch_stall = 1'b1; drive(OpJmp, 32'd99, 32'd0, 32'd0, 4'd9, 32'h400);
    tick();
    n_cmp++; if ({o_fetch_stall, o_dep_stall, o_branch_sel} !== 3'b110) begin
      n_fail++; $display("FAIL bub_both got %b%b%b want 110", o_fetch_stall, o_dep_stall, o_branch_sel);
    end
    n_cmp++; if (o_dest_idx !== 4'd2) begin n_fail++; $display("FAIL bub_idx got %0d want 2", o_dest_idx); end
    fetch_stall = 1'b0; dep_stall = 1'b0; lock = 1'b0;
    tick();
    n_cmp++; if ({o_lock, o_fetch_stall, o_dep_stall, o_branch_sel} !== 4'b0000) begin
      n_fail++; $display("FAIL nolock_flags got %b%b%b%b want 0000", o_lock, o_fetch_stall,
                         o_dep_stall, o_branch_sel);
    end
    n_cmp++; if (o_alu !== 32'd12 || o_retire !== exp_cnt) begin
      n_fail++; $display("FAIL nolock_hold got %0d/%0d want 12/%0d", o_alu, o_retire, exp_cnt);
    end
    lock = 1'b1;
  endtask

  task automatic test_branch();
    drive(OpBrz, 32'd0, 32'd0, 32'd0, 4'd0, 32'h40);
    tick();
    exp_cnt++;
    n_cmp++; if (o_branch_sel !== 1'b1 || o_branch_pc !== 32'h40) begin
      n_fail++; $display("FAIL brz got %b/%h want 1/40", o_branch_sel, o_branch_pc);
    end
    n_cmp++; if (o_alu !== 32'd12) begin n_fail++; $display("FAIL brz_alu got %0d want 12", o_alu); end
    drive(OpAddD, 32'd1, 32'd2, 32'd0, 4'd1, 32'd0);
    tick();
    exp_cnt++;
    n_cmp++; if (o_branch_sel !== 1'b0) begin n_fail++; $display("FAIL brz_drop got %b want 0", o_branch_sel); end
    drive(OpJmp, 32'd0, 32'd0, 32'd0, 4'd0, 32'h80);
    tick();
    exp_cnt++;
    n_cmp++; if (o_branch_sel !== 1'b1 || o_branch_pc !== 32'h80) begin
      n_fail++; $display("FAIL jmp1 got %b/%h want 1/80", o_branch_sel, o_branch_pc);
    end
    dest_value = 32'hC0;
    tick();
    exp_cnt++;
    n_cmp++; if (o_branch_sel !== 1'b1 || o_branch_pc !== 32'hC0) begin
      n_fail++; $display("FAIL jmp2 got %b/%h want 1/c0", o_branch_sel, o_branch_pc);
    end
    drive(8'hEE, 32'd77, 32'd77, 32'd0, 4'd4, 32'h500);
    tick();
    exp_cnt++;
    n_cmp++; if (o_branch_sel !== 1'b0 || o_alu !== 32'd3) begin
      n_fail++; $display("FAIL unknown got %b/%h want 0/3", o_branch_sel, o_alu);
    end
    n_cmp++; if (o_retire !== exp_cnt) begin n_fail++; $display("FAIL br_cnt got %0d want %0d", o_retire, exp_cnt); end
  endtask

  task automatic test_jsr();
    drive(OpJsr, 32'h24, 32'd0, 32'd0, 4'd7, 32'h200);
    tick();
    exp_cnt++;
    n_cmp++; if (o_alu !== 32'h24) begin n_fail++; $display("FAIL jsr_link got %h want 24", o_alu); end
    n_cmp++; if (o_dest_idx !== 4'd7) begin n_fail++; $display("FAIL jsr_idx got %0d want 7", o_dest_idx); end
    n_cmp++; if (o_branch_sel !== 1'b1 || o_branch_pc !== 32'h200) begin
      n_fail++; $display("FAIL jsr_redir got %b/%h want 1/200", o_branch_sel, o_branch_pc);
    end
  endtask

  task automatic test_wrap_and_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(OpAddD, 32'd1, 32'd1, 32'd0, 4'd1, 32'd0);
    repeat (15) tick();
    n_cmp++; if (o_retire !== 4'd15) begin n_fail++; $display("FAIL cnt15 got %0d want 15", o_retire); end
    tick();
    n_cmp++; if (o_retire !== 4'd0) begin n_fail++; $display("FAIL cnt_wrap got %0d want 0", o_retire); end
    drive(OpBrz, 32'd0, 32'd0, 32'd0, 4'd0, 32'h40);
    tick();
    n_cmp++; if (o_branch_sel !== 1'b1) begin n_fail++; $display("FAIL mid_pre got %b want 1", o_branch_sel); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (o_branch_sel !== 1'b0 || o_branch_pc !== 32'd0 || o_retire !== 4'd0) begin
      n_fail++; $display("FAIL mid_rst got %b/%h/%0d want 0/0/0", o_branch_sel, o_branch_pc, o_retire);
    end
    rst_n = 1'b1;
    drive(OpAddD, 32'd5, 32'd7, 32'd0, 4'd1, 32'd0);
    tick();
    n_cmp++; if (o_branch_sel !== 1'b0 || o_retire !== 4'd1 || o_alu !== 32'd12) begin
      n_fail++; $display("FAIL mid_post got %b/%0d/%0d want 0/1/12", o_branch_sel, o_retire, o_alu);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_alu();
    test_bubble();
    test_branch();
    test_jsr();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
